// File: rtl/fact_bcd_pkg.sv
// Shared types and helpers for the factorial-result BCD converter.
// FACT_BCD_BLANK_EN (in fact_bcd_conv) selects leading-digit blanking.
package fact_bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] BLANK_CODE = 4'hF;

    // ndig is a 4-bit port, so at most 15 digits can be reported.
    localparam int MAX_DIGITS = 15;
    localparam int BCD_MAX_W  = 4 * MAX_DIGITS;

    // Index of the highest nonzero digit plus one; a zero value still shows one digit.
    function automatic logic [3:0] ndig_of(input logic [BCD_MAX_W-1:0] v, input int nd);
        logic [3:0] n;
        n = 4'd1;
        for (int i = 0; i < MAX_DIGITS; i++)
            if (i < nd && v[4*i +: 4] != 4'd0)
                n = 4'(i + 1);
        return n;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: a digit of 5 or more gets +3 before the shift.
module bcd_add3 (
    input  logic [3:0] d,
    output logic [3:0] q
);
    assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

// File: rtl/fact_bcd_conv.sv
// Iterative binary-to-BCD converter (one bit per clock) for the factorial result.
// Define FACT_BCD_BLANK_EN to replace leading zero digits with the blank code.
module fact_bcd_conv #(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 10,
    parameter int CNT_W  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [WIDTH-1:0]      in_data,
    output logic                  ready,
    output logic                  out_valid,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [3:0]            ndig,
    output logic                  overrun
);
    import fact_bcd_pkg::*;

    localparam int BW = 4 * DIGITS;

    state_t                 state, state_nxt;
    logic [WIDTH-1:0]       bin, bin_nxt;
    logic [BW-1:0]          acc, acc_adj, acc_nxt, bcd_fmt;
    logic [BCD_MAX_W-1:0]   acc_ext;
    logic [CNT_W-1:0]       cnt;
    logic [3:0]             ndig_nxt;
    logic                   last;
    logic                   unused_msb;

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .d (acc[4*g +: 4]),
            .q (acc_adj[4*g +: 4])
        );
    end

    // Correct, then shift {acc,bin} left; the accumulator MSB falls off the top.
    always_comb begin
        {acc_nxt, bin_nxt} = {acc_adj[BW-2:0], bin, 1'b0};
        unused_msb         = acc_adj[BW-1];
        acc_ext            = '0;
        acc_ext[BW-1:0]    = acc_nxt;
        ndig_nxt           = ndig_of(acc_ext, DIGITS);
        bcd_fmt            = acc_nxt;
`ifdef FACT_BCD_BLANK_EN
        for (int i = 1; i < DIGITS; i++)
            if (i >= int'(ndig_nxt))
                bcd_fmt[4*i +: 4] = BLANK_CODE;
`else
`endif
    end

    assign last = (state == SHIFT) && (cnt == CNT_W'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:    state_nxt = in_valid ? SHIFT : IDLE;
            SHIFT:   state_nxt = last ? DONE : SHIFT;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ready = (state == IDLE);
    end

    // Results are registered on the final shift edge so they are stable while in DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bin       <= '0;
            acc       <= '0;
            cnt       <= '0;
            bcd       <= '0;
            ndig      <= 4'd1;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            out_valid <= last;
            if (last) begin
                bcd  <= bcd_fmt;
                ndig <= ndig_nxt;
            end
            if (in_valid && !ready)
                overrun <= 1'b1;
            case (state)
                IDLE: if (in_valid) begin
                    bin <= in_data;
                    acc <= '0;
                    cnt <= CNT_W'(WIDTH);
                end
                SHIFT: begin
                    acc <= acc_nxt;
                    bin <= bin_nxt;
                    cnt <= cnt - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fact_bcd_conv.sv
// Directed bench for fact_bcd_conv: latency, ready/overrun, reset abort, n! chain.
module tb_fact_bcd_conv;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        ready, out_valid, overrun;
    logic [39:0] bcd;
    logic [3:0]  ndig;

    int n_cmp = 0;
    int n_err = 0;

    fact_bcd_conv dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .ready     (ready),
        .out_valid (out_valid),
        .bcd       (bcd),
        .ndig      (ndig),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Decimal reference built by repeated division.
    function automatic logic [39:0] to_bcd(input longint v);
        logic [39:0] b;
        b = '0;
        for (int i = 0; i < 10; i++) begin
            b[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return b;
    endfunction

    function automatic logic [3:0] ref_ndig(input longint v);
        logic [3:0] n;
        n = 4'd1;
        while (v >= 10) begin
            v = v / 10;
            n++;
        end
        return n;
    endfunction

    function automatic logic [39:0] exp_fmt(input logic [39:0] raw, input logic [3:0] nd);
        logic [39:0] b;
        b = raw;
`ifdef FACT_BCD_BLANK_EN
        for (int i = 1; i < 10; i++)
            if (i >= int'(nd)) b[4*i +: 4] = 4'hF;
`else
        if (nd == 4'd0) b = '0;
`endif
        return b;
    endfunction

    // Starts and ends just after a falling edge. Optionally pulses a second
    // in_valid carrying 'extra' in cycle 'extra_at' of the conversion.
    task automatic conv(input logic [31:0] v, input int extra_at, input logic [31:0] extra,
                        output logic [39:0] b, output logic [3:0] n, output int lat,
                        output logic rdy_bad, output logic rdy_after);
        lat     = -1;
        rdy_bad = 1'b0;
        b       = '0;
        n       = '0;
        in_valid = 1'b1;
        in_data  = v;
        @(negedge clk);
        for (int k = 1; k <= 40; k++) begin
            if (k == extra_at) begin
                in_valid = 1'b1;
                in_data  = extra;
            end else begin
                in_valid = 1'b0;
            end
            if (ready) rdy_bad = 1'b1;
            if (out_valid) begin
                lat = k;
                b   = bcd;
                n   = ndig;
                break;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        @(negedge clk);
        rdy_after = ready;
    endtask

    logic [39:0] b;
    logic [3:0]  n;
    int          lat;
    logic        rb, ra;
    int          seen;
    longint      f;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_ready", 64'(ready), 64'd1);
        chk("rst_bcd", 64'(bcd), 64'd0);
        chk("rst_ndig", 64'(ndig), 64'd1);
        chk("rst_outv", 64'(out_valid), 64'd0);
        chk("rst_ovr", 64'(overrun), 64'd0);
        rst = 1'b1;
        @(negedge clk);

        conv(32'd0, 0, 32'd0, b, n, lat, rb, ra);
        chk("zero_lat", 64'(lat), 64'd33);
        chk("zero_bcd", 64'(b), 64'(exp_fmt(40'h0, 4'd1)));
        chk("zero_ndig", 64'(n), 64'd1);

        conv(32'd479001600, 0, 32'd0, b, n, lat, rb, ra);
        chk("f12_lat", 64'(lat), 64'd33);
        chk("f12_bcd", 64'(b), 64'(exp_fmt(40'h0479001600, 4'd9)));
        chk("f12_ndig", 64'(n), 64'd9);
        chk("f12_rdy_busy", 64'(rb), 64'd0);
        chk("f12_rdy_after", 64'(ra), 64'd1);
        repeat (3) @(negedge clk);
        chk("hold_bcd", 64'(bcd), 64'(exp_fmt(40'h0479001600, 4'd9)));
        chk("hold_outv", 64'(out_valid), 64'd0);

        conv(32'hFFFF_FFFF, 0, 32'd0, b, n, lat, rb, ra);
        chk("max_bcd", 64'(b), 64'h42_9496_7295);
        chk("max_ndig", 64'(n), 64'd10);
        chk("ovr_before", 64'(overrun), 64'd0);

        conv(32'd120, 10, 32'd720, b, n, lat, rb, ra);
        chk("ovr_lat", 64'(lat), 64'd33);
        chk("ovr_bcd", 64'(b), 64'(exp_fmt(40'h0000000120, 4'd3)));
        chk("ovr_ndig", 64'(n), 64'd3);
        chk("ovr_set", 64'(overrun), 64'd1);
        conv(32'd5040, 0, 32'd0, b, n, lat, rb, ra);
        chk("ovr_clean_bcd", 64'(b), 64'(exp_fmt(40'h0000005040, 4'd4)));
        chk("ovr_sticky", 64'(overrun), 64'd1);

        // Reset in the middle of a conversion aborts it.
        in_valid = 1'b1;
        in_data  = 32'd3628800;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (14) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_bcd", 64'(bcd), 64'd0);
        chk("abort_ndig", 64'(ndig), 64'd1);
        chk("abort_ovr", 64'(overrun), 64'd0);
        chk("abort_ready", 64'(ready), 64'd1);
        repeat (2) @(negedge clk);
        rst  = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("abort_no_outv", 64'(seen), 64'd0);
        conv(32'd1, 0, 32'd0, b, n, lat, rb, ra);
        chk("one_lat", 64'(lat), 64'd33);
        chk("one_bcd", 64'(b), 64'(exp_fmt(40'h1, 4'd1)));

        f = 1;
        for (int k = 1; k <= 12; k++) begin
            f = f * k;
            conv(32'(f), 0, 32'd0, b, n, lat, rb, ra);
            chk($sformatf("fact%0d_bcd", k), 64'(b), 64'(exp_fmt(to_bcd(f), ref_ndig(f))));
            chk($sformatf("fact%0d_ndig", k), 64'(n), 64'(ref_ndig(f)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fact_bcd_conv.md
Name: fact_bcd_conv

Overview:
- Downstream stage of the factorial engine. Consumes its 32-bit result on the done tick.
- Converts the result to packed BCD with an iterative shift-add-3 (double-dabble) algorithm, one bit per clock.
- Presents decimal digits and a significant-digit count to the display/UART formatting logic.
- Signals when it can accept a new value and flags results lost while busy.

Parameters:
- WIDTH, 32, binary input width.
- DIGITS, 10, BCD digits produced. Must satisfy DIGITS >= ceil(WIDTH*log10(2)); 10 for 32.
- CNT_W, 6, width of the bit counter. Must hold WIDTH.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-low reset (asserted at 0); single clock domain.
- in_valid  input  1  one-cycle strobe; connects to the factorial tick.
- in_data  input  WIDTH  binary value; connects to the factorial out.
- ready  output  1  high when a new in_valid will be accepted.
- out_valid  output  1  one-cycle pulse: bcd/ndig updated this cycle.
- bcd  output  4*DIGITS  packed BCD, digit 0 in bits [3:0].
- ndig  output  4  number of significant digits, 1..DIGITS.
- overrun  output  1  sticky: an in_valid arrived while not ready.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, bcd=0, ndig=1, out_valid=0, overrun=0. Internal shift registers and counter are cleared.
- FSM states:
  - IDLE (ready=1): in_valid=1 at an edge captures in_data into the binary shift register, clears the BCD accumulator, loads count=WIDTH, and moves to SHIFT.
  - SHIFT: each cycle, every accumulator digit >=5 gets +3, then {acc,bin} shifts left by 1 and count decrements. When count reaches 1, this cycle is the last shift; next state is DONE.
  - DONE: bcd <= accumulator, ndig <= index of highest nonzero digit + 1 (1 if value is 0), out_valid=1, next state IDLE.
- Latency: capture edge E0, then WIDTH SHIFT cycles, then out_valid high in cycle E0+WIDTH+1 (33 for defaults).
- Throughput: one conversion per WIDTH+2 cycles.
- ready is combinational: (state==IDLE). It is low in SHIFT and DONE.
- in_valid while ready=0: input ignored, conversion in progress unaffected, overrun set to 1. overrun clears only on reset.
- bcd and ndig hold their last value between out_valid pulses. They are registered; there are no combinational paths from inputs.
- Digit correction is on the pre-shift value. The accumulator is DIGITS*4 bits; bits shifted out of the top are discarded. This cannot occur when the DIGITS constraint holds.
- Reset asserted mid-SHIFT aborts the conversion; no out_valid is produced. After release, the block is in IDLE with ready=1.
- Illegal state encoding recovers to IDLE on the next clock.

Optional Feature:
- Macro: FACT_BCD_BLANK_EN.
- Defined: in DONE, every digit above position ndig-1 is written as 4'hF (display blank code). Digit 0 is never blanked.
- Undefined: leading digits are output as 4'h0. ndig is computed identically in both builds.

Decomposition:
- Package fact_bcd_pkg:
  - state enum (IDLE, SHIFT, DONE).
  - BLANK_CODE = 4'hF.
  - function computing ndig from a packed BCD vector.
- Sub-module bcd_add3: combinational 4-bit digit correction (d>=5 gives d+3, else d). Instantiated DIGITS times with a generate loop.

Test Plan:
- Reset, then in_valid with in_data=0 -> out_valid at cycle 33; bcd=40'h0; ndig=1. With FACT_BCD_BLANK_EN: bcd=40'hFFFFFFFFF0.
- in_data=479001600 (12!) -> bcd=40'h0479001600, ndig=9; ready low for cycles 1..32 after capture, high again the cycle after out_valid.
- in_data=32'hFFFFFFFF -> bcd=40'h4294967295, ndig=10, no truncation.
- Capture 120 (5!), pulse in_valid with 720 at cycle 10 -> result bcd=..0120, ndig=3; overrun=1 and stays 1 after a following clean conversion.
- Capture 3628800, drop rst to 0 at cycle 15 for 2 cycles -> no out_valid; bcd=0, ndig=1, overrun=0. Next capture of 1 gives bcd=..01 after 33 cycles.
- Chain with the factorial engine for n=1..12 -> each out_valid bcd matches the decimal n! reference model.
